vga_draw_scheduler: RTL and testbench

- Sequences pixel writes into the 160x120 3-bit-colour VGA adapter on behalf of three requesters: full-screen clear engine, rectangle fill, and single-pixel cursor plot.
- Arbitrates by fixed priority and walks rasters internally at one pixel per clock.
- Drives the adapter's x/y/colour/plot inputs directly from registers.

---
 rtl/vga_draw_scheduler_if.sv | 38 +++
 rtl/vga_draw_scheduler.sv | 139 +++++++++++++
 tb/tb_vga_draw_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_draw_scheduler_if.sv
// Request/ack handshakes and adapter drive lines between the requesters and the draw scheduler.
// The master side is the requester/adapter view; the slave side is the scheduler itself.
interface vga_draw_scheduler_if;
    logic       clear_req;
    logic       fill_req;
    logic [7:0] fill_x0;
    logic [6:0] fill_y0;
    logic [7:0] fill_w;
    logic [6:0] fill_h;
    logic [2:0] fill_colour;
    logic       pix_req;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       clear_ack;
    logic       fill_ack;
    logic       pix_ack;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output clear_req, fill_req, fill_x0, fill_y0, fill_w, fill_h, fill_colour,
               pix_req, pix_x, pix_y, pix_colour,
        input  clear_ack, fill_ack, pix_ack, busy, done,
               vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  clear_req, fill_req, fill_x0, fill_y0, fill_w, fill_h, fill_colour,
               pix_req, pix_x, pix_y, pix_colour,
        output clear_ack, fill_ack, pix_ack, busy, done,
               vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_draw_scheduler.sv
// Fixed-priority pixel-write scheduler for a 160x120 3-bit VGA adapter.
// Clear and rectangle fill are walked as rasters at one pixel per clock; single pixels plot in the accept cycle.
module vga_draw_scheduler #(
    parameter int         XMAX      = 160,
    parameter int         YMAX      = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                  clock,
    input  logic                  resetn,
    vga_draw_scheduler_if.slave   bus
);
    localparam logic [8:0] XLIM    = 9'(XMAX);
    localparam logic [7:0] YLIM    = 8'(YMAX);
    localparam logic [7:0] CLEAR_W = 8'(XMAX);
    localparam logic [6:0] CLEAR_H = 7'(YMAX);

    typedef enum logic [1:0] {IDLE, CLEAR, FILL} state_t;

    state_t     state_reg;
    logic [7:0] cx_reg, x0_reg, w_reg;
    logic [6:0] cy_reg, y0_reg, h_reg;
    logic       clear_ack_reg, fill_ack_reg, pix_ack_reg, busy_reg, done_reg, plot_reg;
    logic [7:0] vga_x_reg;
    logic [6:0] vga_y_reg;
    logic [2:0] vga_colour_reg;

    logic       last_col, last_row, last_pix;
    logic [7:0] cx_next;
    logic [6:0] cy_next;
    logic [8:0] step_x;
    logic [7:0] step_y;
    logic       step_vis, fill_vis, pix_vis;

    // Counters hold the pixel currently on the adapter; the *_next values describe the one after it.
    always_comb begin
        last_col = (cx_reg == w_reg - 8'd1);
        last_row = (cy_reg == h_reg - 7'd1);
        last_pix = (w_reg == 8'd0) || (h_reg == 7'd0) || (last_col && last_row);
        cx_next  = last_col ? 8'd0 : cx_reg + 8'd1;
        cy_next  = last_col ? cy_reg + 7'd1 : cy_reg;
        step_x   = {1'b0, x0_reg} + {1'b0, cx_next};
        step_y   = {1'b0, y0_reg} + {1'b0, cy_next};
        step_vis = (step_x < XLIM) && (step_y < YLIM);
        fill_vis = (bus.fill_w != 8'd0) && (bus.fill_h != 7'd0) &&
                   ({1'b0, bus.fill_x0} < XLIM) && ({1'b0, bus.fill_y0} < YLIM);
        pix_vis  = ({1'b0, bus.pix_x} < XLIM) && ({1'b0, bus.pix_y} < YLIM);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cx_reg         <= '0;
            cy_reg         <= '0;
            x0_reg         <= '0;
            y0_reg         <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            clear_ack_reg  <= 1'b0;
            fill_ack_reg   <= 1'b0;
            pix_ack_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            plot_reg       <= 1'b0;
            vga_x_reg      <= '0;
            vga_y_reg      <= '0;
            vga_colour_reg <= '0;
        end else begin
            clear_ack_reg <= 1'b0;
            fill_ack_reg  <= 1'b0;
            pix_ack_reg   <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    plot_reg <= 1'b0;
                    cx_reg   <= '0;
                    cy_reg   <= '0;
                    if (bus.clear_req) begin
                        // Clear reuses the fill raster walker over the whole screen.
                        state_reg      <= CLEAR;
                        clear_ack_reg  <= 1'b1;
                        busy_reg       <= 1'b1;
                        x0_reg         <= '0;
                        y0_reg         <= '0;
                        w_reg          <= CLEAR_W;
                        h_reg          <= CLEAR_H;
                        vga_x_reg      <= '0;
                        vga_y_reg      <= '0;
                        vga_colour_reg <= BG_COLOUR;
                        plot_reg       <= 1'b1;
                    end else if (bus.fill_req) begin
                        state_reg      <= FILL;
                        fill_ack_reg   <= 1'b1;
                        busy_reg       <= 1'b1;
                        x0_reg         <= bus.fill_x0;
                        y0_reg         <= bus.fill_y0;
                        w_reg          <= bus.fill_w;
                        h_reg          <= bus.fill_h;
                        vga_x_reg      <= bus.fill_x0;
                        vga_y_reg      <= bus.fill_y0;
                        vga_colour_reg <= bus.fill_colour;
                        plot_reg       <= fill_vis;
                    end else if (bus.pix_req) begin
                        pix_ack_reg    <= 1'b1;
                        vga_x_reg      <= bus.pix_x;
                        vga_y_reg      <= bus.pix_y;
                        vga_colour_reg <= bus.pix_colour;
                        plot_reg       <= pix_vis;
                    end
                end
                CLEAR, FILL: begin
                    if (last_pix) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        plot_reg  <= 1'b0;
                    end else begin
                        cx_reg    <= cx_next;
                        cy_reg    <= cy_next;
                        vga_x_reg <= step_x[7:0];
                        vga_y_reg <= step_y[6:0];
                        plot_reg  <= step_vis;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.clear_ack  = clear_ack_reg;
    assign bus.fill_ack   = fill_ack_reg;
    assign bus.pix_ack    = pix_ack_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.vga_x      = vga_x_reg;
    assign bus.vga_y      = vga_y_reg;
    assign bus.vga_colour = vga_colour_reg;
    assign bus.vga_plot   = plot_reg;
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Self-checking bench: table of fill/pixel vectors plus hand sequences for reset, contention and mid-fill reset.
// Every plotted pixel is checked against a queue of expected pixels pushed when the request is driven.
module tb_vga_draw_scheduler;
    logic clock;
    logic resetn;

    vga_draw_scheduler_if bus ();

    vga_draw_scheduler dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    // kind: 1 = fill, 2 = single pixel; exp_done = -1 means no done pulse expected
    typedef struct {
        int kind;
        int x0;
        int y0;
        int w;
        int h;
        int colour;
        int exp_plots;
        int exp_done;
    } vec_t;

    pix_t exp_q[$];
    vec_t vecs[10];
    int   checks;
    int   errors;
    int   plot_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h, input int c);
        for (int cy = 0; cy < h; cy++)
            for (int cx = 0; cx < w; cx++)
                if (x0 + cx < 160 && y0 + cy < 120)
                    exp_q.push_back('{x: 8'(x0 + cx), y: 7'(y0 + cy), c: 3'(c)});
    endtask

    // Advance one cycle and run the per-cycle monitor at the falling edge.
    task automatic tick();
        logic ok;
        pix_t got;
        pix_t e;
        @(negedge clock);
        ok = ($countones({bus.clear_ack, bus.fill_ack, bus.pix_ack}) <= 1) &&
             !(bus.done && (bus.clear_ack || bus.fill_ack || bus.pix_ack));
        check("ack_exclusive", 32'(ok), 32'd1);
        if (bus.vga_plot) begin
            plot_count++;
            got = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot", got.x, got.y, got.c);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 32'(got), 32'(e));
            end
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0: return bus.clear_ack;
            1: return bus.fill_ack;
            2: return bus.pix_ack;
            default: return bus.done;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int bound, input string name, output int t);
        t = 0;
        do begin
            tick();
            t++;
        end while (!sel_sig(sel) && t < bound);
        if (!sel_sig(sel)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no pulse within %0d cycles expected a pulse", name, bound);
        end
    endtask

    function automatic logic [25:0] all_outputs();
        return {bus.clear_ack, bus.fill_ack, bus.pix_ack, bus.busy, bus.done,
                bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int plots0;
        int done_at;
        string tag;
        tag = $sformatf("vec%0d", idx);
        plots0 = plot_count;
        if (v.kind == 1) push_rect(v.x0, v.y0, v.w, v.h, v.colour);
        else             push_rect(v.x0, v.y0, 1, 1, v.colour);
        bus.fill_x0 = 8'(v.x0); bus.fill_y0 = 7'(v.y0);
        bus.fill_w = 8'(v.w); bus.fill_h = 7'(v.h); bus.fill_colour = 3'(v.colour);
        bus.pix_x = 8'(v.x0); bus.pix_y = 7'(v.y0); bus.pix_colour = 3'(v.colour);
        if (v.kind == 1) bus.fill_req = 1'b1;
        else             bus.pix_req = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(v.kind == 1 ? bus.fill_ack : bus.pix_ack), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'(v.kind == 1));
        check({tag, "_done_in_ack"}, 32'(bus.done), 32'd0);
        bus.fill_req = 1'b0;
        bus.pix_req  = 1'b0;
        // Scramble operands to show they were captured at the accepting edge.
        bus.fill_x0 = 8'd77; bus.fill_y0 = 7'd66; bus.fill_w = 8'd9; bus.fill_colour = 3'd7;
        done_at = -1;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (bus.done && done_at < 0) done_at = t;
        end
        check({tag, "_done_cycle"}, 32'(done_at), 32'(v.exp_done));
        check({tag, "_plot_count"}, 32'(plot_count - plots0), 32'(v.exp_plots));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t;
        int done_seen;
        checks = 0;
        errors = 0;
        plot_count = 0;

        vecs[0] = '{1, 10,  20, 3, 2, 5, 6, 6};
        vecs[1] = '{1, 158, 119, 4, 2, 3, 2, 8};
        vecs[2] = '{1, 50,  60, 0, 4, 7, 0, 1};
        vecs[3] = '{1, 50,  60, 5, 0, 7, 0, 1};
        vecs[4] = '{1, 159, 0,  1, 1, 2, 1, 1};
        vecs[5] = '{2, 5,   7,  0, 0, 6, 1, -1};
        vecs[6] = '{2, 200, 5,  0, 0, 1, 0, -1};
        vecs[7] = '{2, 159, 119, 0, 0, 4, 1, -1};
        vecs[8] = '{1, 0,   0,  2, 3, 6, 6, 6};
        vecs[9] = '{1, 30,  40, 8, 8, 3, 64, 64};

        // Reset with every request high, then contention: clear, then fill, then pixel.
        resetn = 1'b0;
        bus.clear_req = 1'b1; bus.fill_req = 1'b1; bus.pix_req = 1'b1;
        bus.fill_x0 = 8'd2; bus.fill_y0 = 7'd3; bus.fill_w = 8'd2; bus.fill_h = 7'd2; bus.fill_colour = 3'd4;
        bus.pix_x = 8'd7; bus.pix_y = 7'd9; bus.pix_colour = 3'd3;
        repeat (3) tick();
        check("reset_outputs", 32'(all_outputs()), 32'd0);
        push_rect(0, 0, 160, 120, 0);
        resetn = 1'b1;
        wait_sig(0, 4, "clear_ack", t);
        check("clear_ack_latency", 32'(t), 32'd1);
        check("clear_busy", 32'(bus.busy), 32'd1);
        bus.clear_req = 1'b0;
        wait_sig(3, 19300, "clear_done", t);
        check("clear_done_cycle", 32'(t), 32'd19200);
        check("clear_queue_empty", 32'(exp_q.size()), 32'd0);
        check("clear_busy_low_at_done", 32'(bus.busy), 32'd0);
        push_rect(2, 3, 2, 2, 4);
        wait_sig(1, 4, "fill_ack", t);
        check("contention_fill_latency", 32'(t), 32'd1);
        bus.fill_req = 1'b0;
        wait_sig(3, 10, "fill_done", t);
        check("contention_fill_done", 32'(t), 32'd4);
        push_rect(7, 9, 1, 1, 3);
        wait_sig(2, 4, "pix_ack", t);
        check("contention_pix_latency", 32'(t), 32'd1);
        bus.pix_req = 1'b0;
        repeat (3) tick();
        check("contention_queue_empty", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of an 8x8 fill.
        push_rect(30, 40, 8, 8, 3);
        bus.fill_x0 = 8'd30; bus.fill_y0 = 7'd40; bus.fill_w = 8'd8; bus.fill_h = 7'd8; bus.fill_colour = 3'd3;
        bus.fill_req = 1'b1;
        wait_sig(1, 4, "midreset_ack", t);
        bus.fill_req = 1'b0;
        repeat (9) tick();
        check("midreset_plots_before", 32'(exp_q.size()), 32'd54);
        #2 resetn = 1'b0;
        #1 check("midreset_async_outputs", 32'(all_outputs()), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check("midreset_no_done", 32'(done_seen), 32'd0);
        run_vec(vecs[9], 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
